// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state, lamp and direction types for the intersection controller
package traffic_pkg;

    typedef enum logic [2:0] {
        AR_BA    = 3'd0,
        A_GREEN  = 3'd1,
        A_YELLOW = 3'd2,
        AR_AB    = 3'd3,
        B_GREEN  = 3'd4,
        B_YELLOW = 3'd5,
        PED_WALK = 3'd6,
        FLASH    = 3'd7
    } state_t;

    typedef enum logic {
        DIR_A = 1'b0,
        DIR_B = 1'b1
    } dir_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_GREEN  = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;
    localparam logic [1:0] LAMP_OFF    = 2'b11;

    // Counter width covers the longest phase; never narrower than one bit.
    function automatic int cnt_width(input int a, input int b, input int c,
                                     input int d, input int e);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// rtl/tl_phase_timer.sv - phase cycle counter with expiry and minimum-green compares
module tl_phase_timer #(
    parameter int             CW       = 3,
    parameter logic [CW-1:0]  MIN_LAST = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart_i,
    input  logic [CW-1:0] last_i,
    output logic          expired_o,
    output logic          min_done_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign cnt_d      = restart_i ? '0 : cnt_q + 1'b1;
    assign expired_o  = (cnt_q == last_i);
    assign min_done_o = (cnt_q >= MIN_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - two-approach timed intersection controller with ped walk and night flash
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_CYCLES      = 8,
    parameter int MIN_GREEN_CYCLES  = 4,
    parameter int YELLOW_CYCLES     = 3,
    parameter int ALLRED_CYCLES     = 2,
    parameter int WALK_CYCLES       = 6,
    parameter int FLASH_HALF_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_req,
    input  logic       flash_mode,
    output logic [1:0] light_a,
    output logic [1:0] light_b,
    output logic       ped_walk,
    output logic [2:0] phase
);

    if (GREEN_CYCLES < 1 || MIN_GREEN_CYCLES < 1 || MIN_GREEN_CYCLES > GREEN_CYCLES ||
        YELLOW_CYCLES < 1 || ALLRED_CYCLES < 1 || WALK_CYCLES < 1 ||
        FLASH_HALF_CYCLES < 1) begin : g_param_check
        $error("traffic_light_ctrl: illegal timing parameters");
    end

    localparam int CW = cnt_width(GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES,
                                  WALK_CYCLES, FLASH_HALF_CYCLES);

    localparam logic [CW-1:0] GREEN_LAST  = CW'(GREEN_CYCLES - 1);
    localparam logic [CW-1:0] MIN_LAST    = CW'(MIN_GREEN_CYCLES - 1);
    localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_CYCLES - 1);
    localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED_CYCLES - 1);
    localparam logic [CW-1:0] WALK_LAST   = CW'(WALK_CYCLES - 1);
    localparam logic [CW-1:0] FLASH_LAST  = CW'(FLASH_HALF_CYCLES - 1);

    state_t        state_q, state_d;
    logic          ped_pending_q, ped_pending_d;
    dir_t          next_dir_q, next_dir_d;
    logic          blink_q, blink_d;
    logic [CW-1:0] last_sel;
    logic          expired;
    logic          min_done;
    logic          restart;
    logic          entering_walk;

    // In FLASH the timer also restarts each half-period so it paces the blink.
    assign restart       = (state_d != state_q) || (state_q == FLASH && expired);
    assign entering_walk = (state_d == PED_WALK) && (state_q != PED_WALK);

    tl_phase_timer #(
        .CW       (CW),
        .MIN_LAST (MIN_LAST)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .restart_i  (restart),
        .last_i     (last_sel),
        .expired_o  (expired),
        .min_done_o (min_done)
    );

    always_comb begin
        last_sel = ALLRED_LAST;
        case (state_q)
            A_GREEN, B_GREEN:   last_sel = GREEN_LAST;
            A_YELLOW, B_YELLOW: last_sel = YELLOW_LAST;
            PED_WALK:           last_sel = WALK_LAST;
            FLASH:              last_sel = FLASH_LAST;
            default:            last_sel = ALLRED_LAST;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= AR_BA;
            ped_pending_q <= 1'b0;
            next_dir_q    <= DIR_A;
            blink_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
            next_dir_q    <= next_dir_d;
            blink_q       <= blink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            AR_BA: if (expired) begin
                if (flash_mode)         state_d = FLASH;
                else if (ped_pending_q) state_d = PED_WALK;
                else                    state_d = A_GREEN;
            end
            A_GREEN:  if (expired || (ped_pending_q && min_done)) state_d = A_YELLOW;
            A_YELLOW: if (expired) state_d = AR_AB;
            AR_AB: if (expired) begin
                if (flash_mode)         state_d = FLASH;
                else if (ped_pending_q) state_d = PED_WALK;
                else                    state_d = B_GREEN;
            end
            B_GREEN:  if (expired || (ped_pending_q && min_done)) state_d = B_YELLOW;
            B_YELLOW: if (expired) state_d = AR_BA;
            PED_WALK: if (expired) state_d = (next_dir_q == DIR_A) ? A_GREEN : B_GREEN;
            FLASH:    if (!flash_mode) state_d = AR_BA;
            default:  state_d = AR_BA;
        endcase
    end

    always_comb begin
        ped_pending_d = ped_pending_q;
        if (ped_req)            ped_pending_d = 1'b1;
        else if (entering_walk) ped_pending_d = 1'b0;

        next_dir_d = next_dir_q;
        if (entering_walk) next_dir_d = (state_q == AR_AB) ? DIR_B : DIR_A;

        blink_d = blink_q;
        if (state_d == FLASH && state_q != FLASH) blink_d = 1'b1;
        else if (state_q == FLASH && expired)     blink_d = ~blink_q;
    end

    always_comb begin
        light_a  = LAMP_RED;
        light_b  = LAMP_RED;
        ped_walk = 1'b0;
        phase    = state_q;
        case (state_q)
            A_GREEN:  light_a = LAMP_GREEN;
            A_YELLOW: light_a = LAMP_YELLOW;
            B_GREEN:  light_b = LAMP_GREEN;
            B_YELLOW: light_b = LAMP_YELLOW;
            PED_WALK: ped_walk = 1'b1;
            FLASH: begin
                light_a = blink_q ? LAMP_YELLOW : LAMP_OFF;
                light_b = blink_q ? LAMP_RED : LAMP_OFF;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Two-approach (A = main road, B = side road) timed intersection controller. It is the parametrised successor to the single-output free-running red/green/yellow sequencer. It adds:
- per-phase cycle counts
- all-red clearance intervals
- a latched pedestrian request with early green termination and a dedicated walk phase
- a night flash mode

It sits between the board-level request/mode inputs and the lamp driver outputs.

Parameters:
GREEN_CYCLES, 8, maximum green length per approach (>=1)
MIN_GREEN_CYCLES, 4, minimum green before a pedestrian request may end it (1..GREEN_CYCLES)
YELLOW_CYCLES, 3, yellow length (>=1)
ALLRED_CYCLES, 2, all-red clearance length (>=1)
WALK_CYCLES, 6, pedestrian walk phase length (>=1)
FLASH_HALF_CYCLES, 4, flash-mode on/off half-period (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ped_req  in  1  pedestrian button; single-cycle or level, sampled every cycle
flash_mode  in  1  1 = request night flash mode
light_a  out  2  approach A lamp: 00 red, 01 green, 10 yellow, 11 off
light_b  out  2  approach B lamp, same encoding
ped_walk  out  1  1 = walk signal lit
phase  out  3  current state code (debug)

Behaviour:
- Clock, reset and interface: reset reset, asynchronous, active-high; clock clk.
- States and phase codes: AR_BA=0, A_GREEN=1, A_YELLOW=2, AR_AB=3, B_GREEN=4, B_YELLOW=5, PED_WALK=6, FLASH=7.
- On reset (asynchronous):
  - state=AR_BA, phase counter cnt=0, ped_pending=0, next_dir=A, blink=1.
  - Outputs: light_a=00, light_b=00, ped_walk=0, phase=0.
- All outputs are decoded combinationally from registered state, so there is zero latency from state to lamps.
- cnt clears to 0 on every state entry and increments each cycle. A phase of length L expires in the cycle where cnt==L-1, so the state lasts exactly L cycles.
- Normal sequence: AR_BA -> A_GREEN -> A_YELLOW -> AR_AB -> B_GREEN -> B_YELLOW -> AR_BA. Default period is 26 cycles.
- Lamps per state:
  - greens: active approach 01, other 00
  - yellows: active approach 10, other 00
  - AR_* and PED_WALK: both 00
  - ped_walk=1 only in PED_WALK
- Pedestrian request:
  - ped_pending sets on any cycle with ped_req=1.
  - ped_pending clears on entry to PED_WALK. Set has priority over clear in the same cycle.
  - Early termination: in A_GREEN/B_GREEN, the green ends early when ped_pending=1 and cnt>=MIN_GREEN_CYCLES-1.
  - A request during yellow or all-red never shortens anything.
  - At AR_AB/AR_BA expiry with ped_pending=1 (and flash_mode=0): go to PED_WALK, record next_dir (B after AR_AB, A after AR_BA). At PED_WALK expiry, go to the green of next_dir.
- Flash mode:
  - flash_mode is acted on only at AR_AB/AR_BA expiry. flash_mode=1 there selects FLASH; this has priority over ped_pending, and pending is retained.
  - In FLASH, blink starts at 1 on entry and toggles every FLASH_HALF_CYCLES.
  - light_a = blink ? 10 : 11; light_b = blink ? 00 : 11; ped_walk=0.
  - flash_mode=0 sampled in FLASH -> AR_BA on the next edge (full all-red), then the normal sequence.
  - ped_req is still latched during FLASH.
- Reset mid-operation: immediate return to reset values. The pending request is discarded.
- phase always equals the state code.
- Width rules:
  - cnt width = $clog2 of the largest length parameter, with a minimum of 1.
  - No wrap is reachable, because every state exits at or before its length.
- Parameter violations (MIN_GREEN_CYCLES>GREEN_CYCLES, any parameter 0) are an elaboration error.

Decomposition:
- Package traffic_pkg holds:
  - state enum (3-bit, codes above)
  - lamp code constants LAMP_RED/GREEN/YELLOW/OFF
  - direction type
- One natural sub-module, tl_phase_timer:
  - cnt register with clear-on-entry
  - expiry compare against a selected length
  - early-termination compare against MIN_GREEN_CYCLES
- The FSM, ped latch and flash blink stay in the top level.

Test Plan:
1. Reset release, inputs 0 -> AR_BA 2 cycles (00/00), A_GREEN 8 (01/00), A_YELLOW 3 (10/00), AR_AB 2, B_GREEN 8 (00/01), B_YELLOW 3 (00/10); repeats with period 26.
2. ped_req pulse in cycle 1 of A_GREEN -> A_GREEN lasts 4 cycles, A_YELLOW 3, AR_AB 2, PED_WALK 6 (ped_walk=1, 00/00), then B_GREEN.
3. ped_req during B_YELLOW -> B_YELLOW stays 3 cycles, AR_BA 2, PED_WALK 6, then A_GREEN full 8. A second ped_req during PED_WALK produces another walk after the next all-red.
4. flash_mode=1 raised mid A_GREEN -> A_GREEN/A_YELLOW/AR_AB complete normally, then FLASH: light_a 10 x4, 11 x4 repeating; light_b 00 x4, 11 x4. Drop flash_mode -> next edge AR_BA 2 cycles, then A_GREEN.
5. flash_mode=1 and ped_pending=1 at AR_BA expiry -> FLASH, ped_walk=0. On exit, AR_BA then PED_WALK 6, then A_GREEN.
6. reset asserted mid B_GREEN (between edges) -> light_a=00, light_b=00, ped_walk=0, phase=0 immediately. A pending request is lost; after release, the sequence matches scenario 1.
